// File: rtl/poly_fios_pkg.sv
// rtl/poly_fios_pkg.sv - shared word width, FSM states and load-region boundaries
package poly_fios_pkg;

    localparam int WORD_W = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        RUN   = 2'd3
    } state_t;

    // First load index past the A region
    function automatic int a_end(input int s, input int n);
        return n * s;
    endfunction

    // First load index past the B region
    function automatic int b_end(input int s, input int n);
        return 2 * n * s;
    endfunction

    // First load index past the M'0 region
    function automatic int mp_end(input int s, input int n);
        return 2 * n * s + s;
    endfunction

    // Words in a complete operand set
    function automatic int load_total(input int s, input int n);
        return 2 * n * s + 2 * s;
    endfunction

    // Counter width that still works for a count of one
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/poly_operand_bank.sv
// rtl/poly_operand_bank.sv - word-addressed operand store with a wrapping window pointer
module poly_operand_bank
    import poly_fios_pkg::*;
#(
    parameter int ROWS       = 5,
    parameter int COLS       = 5,
    // 1: pointer picks a row and the window is that whole row (A style)
    // 0: pointer picks a column and the window is that column across rows (B style)
    parameter bit ROW_WINDOW = 1'b1,
    localparam int DEPTH     = ROWS * COLS,
    localparam int AW        = width_of(DEPTH),
    localparam int PTR_MOD   = ROW_WINDOW ? ROWS : COLS,
    localparam int PW        = width_of(PTR_MOD),
    localparam int WIN       = ROW_WINDOW ? COLS : ROWS
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic                  advance,
    input  logic                  clear,
    output logic [WIN*WORD_W-1:0] window
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     ptr_q;

    // Storage: linear write address, row-major (row = address / COLS)
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read pointer: clear has priority over advance, wraps at PTR_MOD-1
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr_q <= '0;
        end else if (clear) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (ptr_q == PW'(PTR_MOD - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    generate
        for (genvar j = 0; j < WIN; j++) begin : g_win
            if (ROW_WINDOW) begin : g_row
                assign window[j*WORD_W +: WORD_W] = mem[AW'(int'(ptr_q) * COLS + j)];
            end else begin : g_col
                assign window[j*WORD_W +: WORD_W] = mem[AW'(j * COLS + int'(ptr_q))];
            end
        end
    endgenerate

endmodule

// File: rtl/poly_fios_operand_feeder.sv
// rtl/poly_fios_operand_feeder.sv - operand load, start sequencing and strobe service for the FIOS multiplier
module poly_fios_operand_feeder
    import poly_fios_pkg::*;
#(
    parameter int s = 5,
    parameter int N = 5
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    input  logic [WORD_W-1:0]     in_data_i,
    output logic                  in_ready_o,
    input  logic                  start_i,
    output logic                  loaded_o,
    output logic                  busy_o,
    output logic                  FIOS_start_o,
    input  logic                  FIOS_done_i,
    input  logic                  A_rot_i,
    input  logic                  B_shift_i,
    input  logic                  M_prime_0_rot_i,
    input  logic                  M_shift_i,
    output logic [s*WORD_W-1:0]   A_o,
    output logic [N*WORD_W-1:0]   B_o,
    output logic [WORD_W-1:0]     M_prime_0_o,
    output logic [WORD_W-1:0]     M_o
);

    localparam int TOTAL = load_total(s, N);
    localparam int KW    = width_of(TOTAL);
    localparam int AB_AW = width_of(N * s);
    localparam int W_AW  = width_of(s);

    localparam logic [KW-1:0] A_END  = KW'(a_end(s, N));
    localparam logic [KW-1:0] B_END  = KW'(b_end(s, N));
    localparam logic [KW-1:0] MP_END = KW'(mp_end(s, N));
    localparam logic [KW-1:0] LAST   = KW'(TOTAL - 1);

    state_t        state_q, state_d;
    logic [KW-1:0] cnt_q;
    logic          loaded_q;
    logic          ready_en_q;
    logic          accept;
    logic          last_word;
    logic          run_adv;
    logic          ptr_clear;
    logic          a_we, b_we, mp_we, m_we;

    assign accept    = in_valid_i && in_ready_o;
    assign last_word = accept && (cnt_q == LAST);
    assign loaded_o  = loaded_q;

    // State register
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a word arriving in IDLE beats a simultaneous start request
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end else if (start_i && loaded_q) begin
                    state_d = START;
                end
            end
            LOAD:    if (last_word) state_d = IDLE;
            START:   state_d = RUN;
            RUN:     if (FIOS_done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; ready stays low until the first clock after reset release
    always_comb begin
        in_ready_o   = 1'b0;
        busy_o       = 1'b0;
        FIOS_start_o = 1'b0;
        case (state_q)
            IDLE, LOAD: in_ready_o   = ready_en_q;
            START:      FIOS_start_o = 1'b1;
            RUN:        busy_o       = 1'b1;
            default:    ;
        endcase
    end

    // Load counter and the "complete set stored" flag
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q      <= '0;
            loaded_q   <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (last_word) begin
                cnt_q    <= '0;
                loaded_q <= 1'b1;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
                if (state_q == IDLE) begin
                    loaded_q <= 1'b0;
                end
            end
        end
    end

    assign a_we  = accept && (cnt_q < A_END);
    assign b_we  = accept && (cnt_q >= A_END) && (cnt_q < B_END);
    assign mp_we = accept && (cnt_q >= B_END) && (cnt_q < MP_END);
    assign m_we  = accept && (cnt_q >= MP_END);

    // Strobes only move pointers in RUN; done in the same cycle wins
    assign run_adv   = (state_q == RUN) && !FIOS_done_i;
    assign ptr_clear = (state_q == START) || ((state_q == RUN) && FIOS_done_i);

    poly_operand_bank #(.ROWS(N), .COLS(s), .ROW_WINDOW(1'b1)) u_a_bank (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .wr_en   (a_we),
        .wr_addr (AB_AW'(cnt_q)),
        .wr_data (in_data_i),
        .advance (run_adv && A_rot_i),
        .clear   (ptr_clear),
        .window  (A_o)
    );

    poly_operand_bank #(.ROWS(N), .COLS(s), .ROW_WINDOW(1'b0)) u_b_bank (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .wr_en   (b_we),
        .wr_addr (AB_AW'(cnt_q - A_END)),
        .wr_data (in_data_i),
        .advance (run_adv && B_shift_i),
        .clear   (ptr_clear),
        .window  (B_o)
    );

    poly_operand_bank #(.ROWS(1), .COLS(s), .ROW_WINDOW(1'b0)) u_mp_bank (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .wr_en   (mp_we),
        .wr_addr (W_AW'(cnt_q - B_END)),
        .wr_data (in_data_i),
        .advance (run_adv && M_prime_0_rot_i),
        .clear   (ptr_clear),
        .window  (M_prime_0_o)
    );

    poly_operand_bank #(.ROWS(1), .COLS(s), .ROW_WINDOW(1'b0)) u_m_bank (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .wr_en   (m_we),
        .wr_addr (W_AW'(cnt_q - MP_END)),
        .wr_data (in_data_i),
        .advance (run_adv && M_shift_i),
        .clear   (ptr_clear),
        .window  (M_o)
    );

endmodule

// File: tb/tb_poly_fios_operand_feeder.sv
// tb/tb_poly_fios_operand_feeder.sv - scoreboard bench for poly_fios_operand_feeder
module tb_poly_fios_operand_feeder;

    localparam int S  = 5;
    localparam int NC = 5;
    localparam int W  = 17;

    logic            clock_i = 1'b0;
    logic            reset_i;
    logic            in_valid_i;
    logic [W-1:0]    in_data_i;
    logic            in_ready_o;
    logic            start_i;
    logic            loaded_o;
    logic            busy_o;
    logic            FIOS_start_o;
    logic            FIOS_done_i;
    logic            A_rot_i, B_shift_i, M_prime_0_rot_i, M_shift_i;
    logic [S*W-1:0]  A_o;
    logic [NC*W-1:0] B_o;
    logic [W-1:0]    M_prime_0_o;
    logic [W-1:0]    M_o;

    poly_fios_operand_feeder #(.s(S), .N(NC)) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .in_valid_i      (in_valid_i),
        .in_data_i       (in_data_i),
        .in_ready_o      (in_ready_o),
        .start_i         (start_i),
        .loaded_o        (loaded_o),
        .busy_o          (busy_o),
        .FIOS_start_o    (FIOS_start_o),
        .FIOS_done_i     (FIOS_done_i),
        .A_rot_i         (A_rot_i),
        .B_shift_i       (B_shift_i),
        .M_prime_0_rot_i (M_prime_0_rot_i),
        .M_shift_i       (M_shift_i),
        .A_o             (A_o),
        .B_o             (B_o),
        .M_prime_0_o     (M_prime_0_o),
        .M_o             (M_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [S*W-1:0]  a;
        logic [NC*W-1:0] b;
        logic [W-1:0]    mp;
        logic [W-1:0]    m;
    } win_t;

    win_t sb[$];

    logic [W-1:0] a_m [NC][S];
    logic [W-1:0] b_m [NC][S];
    logic [W-1:0] mp_m [S];
    logic [W-1:0] m_m [S];
    int a_p, b_p, mp_p, m_p;
    bit model_run;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++)
            for (int j = 0; j < S; j++) begin
                a_m[i][j] = '0;
                b_m[i][j] = '0;
            end
        for (int j = 0; j < S; j++) begin
            mp_m[j] = '0;
            m_m[j]  = '0;
        end
        a_p = 0; b_p = 0; mp_p = 0; m_p = 0;
        model_run = 1'b0;
    endtask

    task automatic model_write(input int k, input logic [W-1:0] d);
        if (k < NC*S)              a_m[k/S][k%S] = d;
        else if (k < 2*NC*S)       b_m[(k-NC*S)/S][(k-NC*S)%S] = d;
        else if (k < 2*NC*S + S)   mp_m[k-2*NC*S] = d;
        else                       m_m[k-2*NC*S-S] = d;
    endtask

    function automatic win_t model_win();
        win_t w;
        for (int j = 0; j < S; j++)  w.a[j*W +: W] = a_m[a_p][j];
        for (int i = 0; i < NC; i++) w.b[i*W +: W] = b_m[i][b_p];
        w.mp = mp_m[mp_p];
        w.m  = m_m[m_p];
        return w;
    endfunction

    task automatic push_exp();
        sb.push_back(model_win());
    endtask

    task automatic compare_win(input string tag);
        win_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 128'd0, 128'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_A"},  A_o,         e.a);
            check({tag, "_B"},  B_o,         e.b);
            check({tag, "_MP"}, M_prime_0_o, e.mp);
            check({tag, "_M"},  M_o,         e.m);
        end
    endtask

    task automatic load_words(input int base, input int count, input bit gap);
        int hs;
        hs = 0;
        for (int k = 0; k < count; k++) begin
            int  tries;
            bit  took;
            tries = 0;
            took  = 1'b0;
            while (!took && tries < 20) begin
                if (gap) begin
                    in_valid_i = 1'b0;
                    step();
                end
                in_valid_i = 1'b1;
                in_data_i  = W'(base + k);
                took       = in_ready_o;
                step();
                tries++;
            end
            in_valid_i = 1'b0;
            if (took) begin
                model_write(k, W'(base + k));
                hs++;
            end else begin
                check("load_handshake_timeout", 128'd0, 128'd1);
            end
            if (k == 0)         check("loaded_clr_first_word", loaded_o, 1'b0);
            if (k == count - 2) check("loaded_low_before_last", loaded_o, 1'b0);
        end
        check("load_handshakes", hs, count);
        check("loaded_after_load", loaded_o, count == 2*NC*S + 2*S);
    endtask

    task automatic do_start(input bit expect_go, input string tag);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check({tag, "_fios_start"}, FIOS_start_o, expect_go);
        check({tag, "_busy_in_start"}, busy_o, 1'b0);
        step();
        check({tag, "_fios_start_1cyc"}, FIOS_start_o, 1'b0);
        check({tag, "_busy_run"}, busy_o, expect_go);
        if (expect_go) model_run = 1'b1;
    endtask

    task automatic strobe(input bit a, input bit b, input bit mp, input bit m,
                          input bit done, input string tag);
        A_rot_i = a; B_shift_i = b; M_prime_0_rot_i = mp; M_shift_i = m;
        FIOS_done_i = done;
        if (model_run) begin
            if (done) begin
                a_p = 0; b_p = 0; mp_p = 0; m_p = 0;
                model_run = 1'b0;
            end else begin
                if (a)  a_p  = (a_p + 1) % NC;
                if (b)  b_p  = (b_p + 1) % S;
                if (mp) mp_p = (mp_p + 1) % S;
                if (m)  m_p  = (m_p + 1) % S;
            end
        end
        push_exp();
        step();
        A_rot_i = 0; B_shift_i = 0; M_prime_0_rot_i = 0; M_shift_i = 0;
        FIOS_done_i = 0;
        compare_win(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_word [5];
        first_word = '{6, 11, 16, 21, 1};

        reset_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; start_i = 1'b0;
        FIOS_done_i = 1'b0; A_rot_i = 1'b0; B_shift_i = 1'b0;
        M_prime_0_rot_i = 1'b0; M_shift_i = 1'b0;
        model_clear();

        step(); step();
        check("rst_in_ready", in_ready_o, 1'b0);
        check("rst_loaded", loaded_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_fios_start", FIOS_start_o, 1'b0);
        push_exp();
        compare_win("rst_win");
        reset_i = 1'b1;
        step();
        check("in_ready_after_rst", in_ready_o, 1'b1);

        // Full load 1..60 and the initial windows
        load_words(1, 60, 1'b0);
        push_exp();
        compare_win("after_load");
        for (int j = 0; j < S; j++)  check("A_word", A_o[j*W +: W], W'(j + 1));
        for (int i = 0; i < NC; i++) check("B_coef", B_o[i*W +: W], W'(26 + 5*i));
        check("MP0", M_prime_0_o, W'(51));
        check("M0", M_o, W'(56));

        do_start(1'b1, "start1");

        for (int r = 0; r < NC; r++) begin
            strobe(1, 0, 0, 0, 0, "a_rot");
            check("a_rot_first_word", A_o[W-1:0], W'(first_word[r]));
        end

        for (int r = 0; r < S; r++) begin
            strobe(0, 1, 0, 1, 0, "bm_shift");
            if (r == 0) begin
                check("b_shift_coef0", B_o[W-1:0], W'(27));
                check("m_shift", M_o, W'(57));
            end
        end
        check("b_wrap", B_o[W-1:0], W'(26));

        strobe(1, 0, 1, 0, 0, "a_mp_together");

        // Load attempts and start requests while running are ignored
        in_valid_i = 1'b1;
        in_data_i  = 17'h1ffff;
        start_i    = 1'b1;
        check("run_in_ready", in_ready_o, 1'b0);
        step(); step(); step();
        check("run_no_restart", FIOS_start_o, 1'b0);
        check("run_still_busy", busy_o, 1'b1);
        in_valid_i = 1'b0;
        start_i    = 1'b0;
        push_exp();
        compare_win("run_ignore_load");

        strobe(1, 0, 0, 0, 1, "done_with_rot");
        check("done_busy", busy_o, 1'b0);
        check("done_loaded", loaded_o, 1'b1);
        check("done_in_ready", in_ready_o, 1'b1);

        strobe(1, 1, 1, 1, 0, "idle_strobe");

        do_start(1'b1, "start2");
        strobe(0, 1, 0, 0, 0, "rerun_b");
        check("rerun_b_coef0", B_o[W-1:0], W'(27));
        strobe(0, 0, 0, 0, 1, "rerun_done");

        // Reset mid-load aborts and leaves nothing to start
        load_words(100, 30, 1'b0);
        reset_i = 1'b0;
        #1;
        model_clear();
        check("midrst_loaded", loaded_o, 1'b0);
        check("midrst_in_ready", in_ready_o, 1'b0);
        push_exp();
        compare_win("midrst_win");
        step();
        reset_i = 1'b1;
        step();
        do_start(1'b0, "start_unloaded");

        // Stalled load with valid toggling every other cycle
        load_words(200, 60, 1'b1);
        push_exp();
        compare_win("gap_load");
        check("gap_A0", A_o[W-1:0], W'(200));
        check("gap_M0", M_o, W'(255));
        do_start(1'b1, "start3");
        strobe(0, 0, 0, 1, 0, "gap_m_shift");
        check("gap_m_shift_val", M_o, W'(256));
        strobe(0, 0, 0, 0, 1, "gap_done");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/poly_fios_operand_feeder.md
# poly_fios_operand_feeder

Upstream operand stage for the polynomial FIOS Montgomery multiplier. It accepts a complete operand set as a stream of 17-bit words: polynomial A, polynomial B, the per-word Montgomery constant M'0 and modulus words M. It stores the set, issues the multiplier start pulse, and serves the multiplier's rotate/shift strobes by presenting the current coefficient or word windows. A loaded set can be reused for repeated multiplications without reloading.

## Interface
Parameters:
- s, 5, 17-bit words per coefficient
- N, 5, coefficients per polynomial

Ports:
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- in_valid_i  in  1  load word valid
- in_data_i  in  17  load word
- in_ready_o  out  1  load word accepted when valid & ready
- start_i  in  1  request a multiplication with the stored set
- loaded_o  out  1  a complete operand set is stored
- busy_o  out  1  multiplication in progress
- FIOS_start_o  out  1  one-cycle start pulse to the multiplier
- FIOS_done_i  in  1  multiplier completion
- A_rot_i, B_shift_i, M_prime_0_rot_i, M_shift_i  in  1 each  multiplier strobes
- A_o  out  s*17  all s words of A coefficient a_ptr, word 0 in the LSBs
- B_o  out  N*17  word b_ptr of every B coefficient, coefficient 0 in the LSBs
- M_prime_0_o  out  17  M'0 word mp_ptr
- M_o  out  17  M word m_ptr

## Operation
- Load order, word index k = 0 .. 2Ns+2s-1:
  - A: N·s words, coefficient-major. Word k goes to coefficient k/s, word k%s.
  - B: N·s words, same ordering.
  - M'0: s words.
  - M: s words.
- States and transitions:
  - IDLE:
    - in_ready_o = 1.
    - The first accepted word clears loaded_o, moves to LOAD and counts as word 0.
    - start_i with loaded_o = 1 moves to START.
    - start_i with loaded_o = 0 is ignored.
  - LOAD:
    - in_ready_o = 1.
    - Each accepted word increments the counter.
    - After the last word, loaded_o is set and the state returns to IDLE.
    - in_valid_i = 0 stalls the load indefinitely.
  - START:
    - FIOS_start_o = 1 for exactly one cycle.
    - All pointers are zero.
    - Next state is RUN.
  - RUN:
    - busy_o = 1 and in_ready_o = 0.
    - Each strobe advances its pointer by 1, with wrap: a_ptr N-1 → 0; b_ptr, mp_ptr and m_ptr s-1 → 0.
    - Strobes asserted together all apply in the same cycle.
    - FIOS_done_i moves to IDLE, clears all pointers and keeps loaded_o = 1.
- Strobes outside RUN are ignored.
- FIOS_done_i outside RUN is ignored.
- If FIOS_done_i and a strobe occur in the same cycle, done wins and pointers go to 0.
- start_i during LOAD, START or RUN is ignored. Requests are not queued.
- Pointer arithmetic is modulo-counter only. The block does no data arithmetic.

## Timing
- Reset values, active while reset_i = 0:
  - state IDLE; all counters and pointers 0.
  - in_ready_o 0 during reset, 1 from the first cycle after release.
  - loaded_o, busy_o and FIOS_start_o all 0.
  - Storage cleared to 0, so A_o, B_o, M_prime_0_o and M_o read 0.
- Reset asserted mid-LOAD or mid-RUN aborts immediately. loaded_o reads 0 after release.
- Output windows are combinational muxes from registered storage and pointers. A strobe in cycle t changes the window from cycle t+1.
- Full load takes 2Ns+2s accepted cycles (60 at defaults). loaded_o rises the cycle after the last handshake.
- From start_i sampled high in IDLE:
  - FIOS_start_o is high in the next cycle.
  - busy_o is high from the cycle after that.
- busy_o falls the cycle after FIOS_done_i. start_i is accepted again from that cycle.

## Structure
- Shared package poly_fios_pkg holds:
  - WORD_W = 17.
  - The state enum {IDLE, LOAD, START, RUN}.
  - Load-region boundary functions of s and N.
- Sub-module poly_operand_bank: a word-addressed register file with a write port and a wrapping read pointer (advance and clear inputs). It is instantiated for A, B, M'0 and M; the A and B banks expose full-window read ports.
- The top level holds the FSM, load counter, region decode and strobe gating.

## Test plan
- Load words 1..60 at defaults, then start_i → FIOS_start_o one cycle; A_o words 0..4 = 1..5; B_o coefficient i = 26+5i; M_prime_0_o = 51; M_o = 56.
- In RUN, 5 A_rot_i pulses → A_o steps through coefficients 1, 2, 3, 4, 0 (first word 6, 11, 16, 21, 1).
- B_shift_i and M_shift_i asserted together → B_o coefficient 0 = 27 and M_o = 57 in the next cycle; 5 pulses in total wrap both back to word 0.
- FIOS_done_i together with A_rot_i → a_ptr = 0, state IDLE, loaded_o = 1; a second start_i reruns without reload.
- reset_i low after 30 load words → loaded_o = 0 and all outputs 0; start_i then produces no FIOS_start_o.
- Toggle in_valid_i every other cycle → load completes after exactly 60 handshakes; in_valid_i during RUN is never accepted (in_ready_o = 0).
